// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman host-side datapath.
package hangman_pkg;

  localparam int WORD_LEN = 5;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;
  localparam logic [7:0] ASCII_FILL  = 8'h5F;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    ARM    = 2'd1,
    LOCKED = 2'd2
  } entry_state_t;

endpackage

// File: rtl/ascii_normalize.sv
// Folds an ASCII byte to upper case and flags whether it is a letter.
module ascii_normalize (
  input  logic [7:0] in_byte,
  input  logic       unused_ok,
  output logic [7:0] out_byte,
  output logic       is_letter
);
  import hangman_pkg::*;

  // Classify the byte and subtract the case offset for lower-case letters.
  always_comb begin
    out_byte  = in_byte;
    is_letter = 1'b0;
    if (in_byte >= ASCII_A && in_byte <= ASCII_Z) begin
      is_letter = 1'b1;
    end else if (in_byte >= ASCII_LA && in_byte <= ASCII_LZ) begin
      out_byte  = in_byte - CASE_OFFSET;
      is_letter = 1'b1;
    end
    if (!unused_ok) begin
      out_byte = out_byte;
    end
  end

endmodule

// File: rtl/word_entry.sv
// Secret-word entry stage: builds an upper-case word from keystrokes,
// confirms it onto setWord, and stays locked until the game finishes.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   EDIT   | accepting letters, backspace and confirm
//   ARM    | single cycle after confirm, toggle_state pulses
//   LOCKED | game running, keys ignored until game_done
module word_entry #(
  parameter int         WORD_LEN = 5,
  parameter logic [7:0] FILL     = 8'h5F
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic [7:0]                     key_letter,
  input  logic                           key_strobe,
  input  logic                           key_del,
  input  logic                           key_enter,
  input  logic                           game_done,
  output logic [8*WORD_LEN-1:0]          setWord,
  output logic [8*WORD_LEN-1:0]          preview,
  output logic [$clog2(WORD_LEN+1)-1:0]  count,
  output logic                           toggle_state,
  output logic                           word_ready,
  output logic                           err
);
  import hangman_pkg::*;

  localparam int            CW   = $clog2(WORD_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(WORD_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  entry_state_t              state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [8*WORD_LEN-1:0]     buf_q, buf_d;
  logic [8*WORD_LEN-1:0]     set_word_q, set_word_d;
  logic                      err_q, err_d;
  logic                      toggle_q, toggle_d;
  logic                      ready_q, ready_d;

  logic [7:0]                norm_byte;
  logic                      norm_is_letter;

  ascii_normalize u_norm (
    .in_byte   (key_letter),
    .unused_ok (1'b1),
    .out_byte  (norm_byte),
    .is_letter (norm_is_letter)
  );

  // Next-state, buffer edits and output pulses; enter beats del beats letter.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    buf_d      = buf_q;
    set_word_d = set_word_q;
    err_d      = 1'b0;
    toggle_d   = 1'b0;
    ready_d    = 1'b0;
    unique case (state_q)
      EDIT: begin
        if (key_enter) begin
          if (count_q == FULL) begin
            set_word_d = buf_q;
            state_d    = ARM;
            toggle_d   = 1'b1;
            ready_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_del) begin
          if (count_q != '0) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (i == int'(count_q) - 1) buf_d[8*(WORD_LEN-1-i) +: 8] = FILL;
            end
            count_d = count_q - ONE;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_strobe) begin
          if (norm_is_letter && count_q < FULL) begin
            for (int i = 0; i < WORD_LEN; i++) begin
              if (i == int'(count_q)) buf_d[8*(WORD_LEN-1-i) +: 8] = norm_byte;
            end
            count_d = count_q + ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ARM: begin
        state_d = LOCKED;
        ready_d = 1'b1;
      end
      LOCKED: begin
        ready_d = 1'b1;
        if (game_done) begin
          buf_d   = {WORD_LEN{FILL}};
          count_d = '0;
          state_d = EDIT;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = EDIT;
      end
    endcase
  end

  // Register everything; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= EDIT;
      count_q    <= '0;
      buf_q      <= {WORD_LEN{FILL}};
      set_word_q <= '0;
      err_q      <= 1'b0;
      toggle_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
      set_word_q <= set_word_d;
      err_q      <= err_d;
      toggle_q   <= toggle_d;
      ready_q    <= ready_d;
    end
  end

  assign setWord      = set_word_q;
  assign preview      = buf_q;
  assign count        = count_q;
  assign toggle_state = toggle_q;
  assign word_ready   = ready_q;
  assign err          = err_q;

endmodule

// File: doc/word_entry.md
# word_entry

Host-side word entry stage for wireless hangman. Accepts ASCII keystrokes one at a time, normalises them to upper case, and builds a fixed-length secret word with backspace and confirm. On confirm it freezes the word on `setWord` and emits the `toggle_state` pulse that starts `Game_logic`. It stays locked until the game reports completion.

## Interface
- `WORD_LEN`, default 5: letters per word.
- `FILL`, default 8'h5F ('_'): byte shown in unfilled `preview` slots.

- `clk`  in  1: system clock.
- `nRst`  in  1: reset, synchronous, active-low.
  - One clock; reset is synchronous and active-low.
- `key_letter`  in  8: ASCII byte, qualified by `key_strobe`.
- `key_strobe`  in  1: one-cycle pulse, letter available.
- `key_del`  in  1: one-cycle pulse, backspace.
- `key_enter`  in  1: one-cycle pulse, confirm word.
- `game_done`  in  1: pulse or level from game logic (win or loss). Unlocks entry.
- `setWord`  out  8*WORD_LEN: confirmed word. First letter is in the MSB byte ([39:32] for the default).
- `preview`  out  8*WORD_LEN: word being edited. Unfilled slots hold `FILL`.
- `count`  out  $clog2(WORD_LEN+1): letters currently entered.
- `toggle_state`  out  1: one-cycle confirm pulse to `Game_logic`.
- `word_ready`  out  1: high while the word is locked.
- `err`  out  1: one-cycle pulse when a key is rejected.

## Operation
- **States.**
  - EDIT: accepts keys.
  - ARM: one cycle, drives `toggle_state`.
  - LOCKED: ignores keys.
- **Key normalisation.**
  - 'A'–'Z' (0x41–0x5A) pass unchanged.
  - 'a'–'z' (0x61–0x7A) map to byte − 0x20.
  - Any other byte is invalid.
- **EDIT, simultaneous keys.** Priority is enter > del > letter. Lower-priority keys in the same cycle are dropped silently, with no `err`.
- **EDIT, letter.**
  - Valid letter with `count < WORD_LEN`: written to slot `count` (slot 0 = MSB byte), then `count`+1.
  - Invalid letter, or `count == WORD_LEN`: `err` pulses and state is unchanged.
- **EDIT, del.**
  - `count > 0`: slot `count−1` returns to `FILL`, then `count`−1.
  - `count == 0`: `err` pulses.
- **EDIT, enter.**
  - `count == WORD_LEN`: `setWord` ← buffer, go to ARM.
  - Otherwise: `err` pulses and state stays EDIT.
- **ARM.**
  - `toggle_state` = 1 and `word_ready` = 1.
  - Go to LOCKED next cycle unconditionally.
- **LOCKED.**
  - All key inputs are ignored, with no `err`.
  - `game_done` = 1: buffer fills with `FILL`, `count` ← 0, go to EDIT.
  - `setWord` keeps its last value after unlock until the next confirm.
- **Reset** (`nRst` = 0 at a rising edge), whatever the state:
  - State ← EDIT, `count` ← 0, `preview` all `FILL`.
  - `setWord` ← 0.
  - `toggle_state`, `word_ready`, `err` ← 0.
- **Width rules.**
  - `count` never exceeds `WORD_LEN` and never goes below 0.
  - No wrap-around.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- **Key to visible update.** A key sampled at edge N updates `preview`/`count`/`err` after edge N and they are visible in cycle N+1. `err` is high for exactly cycle N+1.
- **Confirm sequence.** Enter sampled at edge N:
  - `setWord` is valid from cycle N+1.
  - `toggle_state` is high only in cycle N+1.
  - `word_ready` is high from N+1 onward.
  - LOCKED from N+2.
- **Unlock.** `game_done` sampled at edge M in LOCKED: `word_ready` = 0 and `count` = 0 from M+1. Keys are accepted from edge M+1.
- **`game_done` outside LOCKED.** Ignored in EDIT and ARM.
- **Back-to-back keys.** One key per cycle is sustained, with no busy/stall.

## Structure
- **Shared package `hangman_pkg`.** Holds:
  - `WORD_LEN` = 5.
  - ASCII constants: `ASCII_A`, `ASCII_Z`, `ASCII_LA`, `ASCII_LZ`, `ASCII_FILL`.
  - `entry_state_t` enum: EDIT, ARM, LOCKED, encoded as 2 bits.
- **Sub-module `ascii_normalize`.**
  - Combinational.
  - In: byte. Out: upper-case byte plus `is_letter`.
  - Reused later by the guess-capture path.
- **Registers in the top:**
  - State register.
  - `count`.
  - WORD_LEN×8 buffer.
  - `setWord`.
  - `err`/`toggle_state` pulse flops.

## Test plan
1. **Reset.** Drive `nRst` = 0 for 2 cycles → `preview` = 40'h5F5F5F5F5F, `count` = 0, `setWord` = 0, all pulses 0.
2. **Enter APPLE.**
   - Type "apple" (lower case, one key per cycle), then `key_enter` → `setWord` = 40'h4150504C45.
   - `toggle_state` is high exactly one cycle after enter; `word_ready` = 1.
3. **Boundaries.**
   - `key_del` at `count` = 0 → `err` pulse.
   - Type "MOORE", then a 6th 'X' → `err`, `preview` still 40'h4D4F4F5245.
   - Enter after 4 letters → `err`, no `toggle_state`.
4. **Edit and priority.**
   - Type "MOX", `del`, "ORE", enter → `setWord` = 40'h4D4F4F5245.
   - `key_strobe` and `key_del` in the same cycle at `count` = 3 → `count` = 2, no `err`.
5. **Invalid key and lock.**
   - Key '3' (0x33) → `err`, `count` unchanged.
   - In LOCKED, keys produce no change and no `err`.
   - `game_done` → `count` = 0, `word_ready` = 0, new word accepted.
6. **Reset mid-entry.** After "APP", assert `nRst` low for one edge → `count` = 0, `preview` all 0x5F, state EDIT.
